seg_scan_ctrl: RTL and testbench

SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

---
 rtl/seg_scan_ctrl.sv | 102 ++++++++++
 tb/tb_seg_scan_ctrl.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_ctrl.sv
// Scan controller for an 8-digit seven-segment display: steps one digit per prescaler period and
// presents that digit's nibble, anode enable and decimal point from frame-synchronous shadow registers.
module seg_scan_ctrl #(
    parameter int DIV = 100000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] data_in,
    input  logic [7:0]  dp_in,
    input  logic [7:0]  blank_in,
    input  logic        load,
    output logic [3:0]  digit,
    output logic [7:0]  AN,
    output logic        dp,
    output logic [2:0]  digit_idx,
    output logic        frame_done,
    output logic        load_ack
);

    localparam int PW = (DIV > 2) ? $clog2(DIV) : 1;

    logic [PW-1:0] presc;
    logic [31:0]   sh_data, pend_data, sh_data_nxt;
    logic [7:0]    sh_dp, pend_dp, sh_dp_nxt;
    logic [7:0]    sh_blank, pend_blank, sh_blank_nxt;
    logic          pend_vld;

    logic          tick, commit, take;
    logic [2:0]    idx_nxt;
    logic          blanked;
    logic [3:0]    digit_nxt;
    logic [7:0]    an_nxt;
    logic          dp_nxt;

    // Outputs are registered from the post-edge index and shadow state, so a commit is visible
    // on the very edge that moves the scan back to digit 0.
    always_comb begin
        tick         = (presc == PW'(DIV - 1));
        commit       = tick && (digit_idx == 3'd7);
        idx_nxt      = tick ? digit_idx + 3'd1 : digit_idx;
        sh_data_nxt  = sh_data;
        sh_dp_nxt    = sh_dp;
        sh_blank_nxt = sh_blank;
        take         = 1'b0;
        if (commit && load) begin
            sh_data_nxt  = data_in;
            sh_dp_nxt    = dp_in;
            sh_blank_nxt = blank_in;
            take         = 1'b1;
        end else if (commit && pend_vld) begin
            sh_data_nxt  = pend_data;
            sh_dp_nxt    = pend_dp;
            sh_blank_nxt = pend_blank;
            take         = 1'b1;
        end
        blanked   = sh_blank_nxt[idx_nxt];
        digit_nxt = sh_data_nxt[{idx_nxt, 2'b00} +: 4];
        an_nxt    = blanked ? 8'hFF : ~(8'b1 << idx_nxt);
        dp_nxt    = blanked ? 1'b1 : ~sh_dp_nxt[idx_nxt];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            presc      <= '0;
            digit_idx  <= 3'd0;
            sh_data    <= 32'd0;
            sh_dp      <= 8'd0;
            sh_blank   <= 8'hFF;
            pend_vld   <= 1'b0;
            digit      <= 4'd0;
            AN         <= 8'hFF;
            dp         <= 1'b1;
            frame_done <= 1'b0;
            load_ack   <= 1'b0;
        end else begin
            presc      <= tick ? '0 : presc + PW'(1);
            digit_idx  <= idx_nxt;
            sh_data    <= sh_data_nxt;
            sh_dp      <= sh_dp_nxt;
            sh_blank   <= sh_blank_nxt;
            digit      <= digit_nxt;
            AN         <= an_nxt;
            dp         <= dp_nxt;
            frame_done <= commit;
            load_ack   <= take;
            if (take)
                pend_vld <= 1'b0;
            else if (load)
                pend_vld <= 1'b1;
        end
    end

    // Pending data is qualified by pend_vld, so it needs no reset of its own.
    always_ff @(posedge clk) begin
        if (load && !commit) begin
            pend_data  <= data_in;
            pend_dp    <= dp_in;
            pend_blank <= blank_in;
        end
    end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Scoreboard bench for seg_scan_ctrl (DIV = 4): a behavioural model queues the expected outputs
// for each driven cycle, which are popped and compared one cycle later.
module tb_seg_scan_ctrl;

    localparam int DIV = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] data_in = '0;
    logic [7:0]  dp_in = '0;
    logic [7:0]  blank_in = '0;
    logic        load = 1'b0;
    logic [3:0]  digit;
    logic [7:0]  AN;
    logic        dp;
    logic [2:0]  digit_idx;
    logic        frame_done;
    logic        load_ack;

    seg_scan_ctrl #(.DIV(DIV)) dut (
        .clk(clk), .rst(rst), .data_in(data_in), .dp_in(dp_in), .blank_in(blank_in),
        .load(load), .digit(digit), .AN(AN), .dp(dp), .digit_idx(digit_idx),
        .frame_done(frame_done), .load_ack(load_ack)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] digit;
        logic [7:0] an;
        logic       dp;
        logic [2:0] idx;
        logic       frame_done;
        logic       load_ack;
    } exp_t;

    exp_t exp_q[$];

    int n_cmp = 0;
    int n_err = 0;
    int ack_cnt = 0;
    int fd_cnt = 0;

    // Reference model state
    int          m_presc = 0;
    int          m_idx = 0;
    logic [31:0] m_data = '0, m_pdata = '0;
    logic [7:0]  m_dp = '0, m_pdp = '0;
    logic [7:0]  m_blank = 8'hFF, m_pblank = '0;
    bit          m_pv = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] expv);
        n_cmp++;
        if (got !== expv) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, expv, $time);
        end
    endtask

    task automatic model_step(input bit r, input bit ld, input logic [31:0] d,
                              input logic [7:0] p, input logic [7:0] b);
        exp_t e;
        bit tick, commit;
        e.frame_done = 1'b0;
        e.load_ack   = 1'b0;
        if (r) begin
            m_presc = 0; m_idx = 0; m_data = '0; m_dp = '0; m_blank = 8'hFF; m_pv = 0;
        end else begin
            tick   = (m_presc == DIV - 1);
            commit = tick && (m_idx == 7);
            e.frame_done = commit;
            if (commit && ld) begin
                m_data = d; m_dp = p; m_blank = b; m_pv = 0; e.load_ack = 1'b1;
            end else if (commit && m_pv) begin
                m_data = m_pdata; m_dp = m_pdp; m_blank = m_pblank; m_pv = 0; e.load_ack = 1'b1;
            end else if (ld) begin
                m_pdata = d; m_pdp = p; m_pblank = b; m_pv = 1;
            end
            m_presc = tick ? 0 : m_presc + 1;
            if (tick) m_idx = (m_idx + 1) % 8;
        end
        e.idx   = 3'(m_idx);
        e.digit = 4'((m_data >> (4 * m_idx)) & 32'hF);
        if (m_blank[m_idx]) begin
            e.an = 8'hFF;
            e.dp = 1'b1;
        end else begin
            e.an = 8'hFF;
            e.an[m_idx] = 1'b0;
            e.dp = ~m_dp[m_idx];
        end
        exp_q.push_back(e);
    endtask

    task automatic cycle(input bit r, input bit ld, input logic [31:0] d,
                         input logic [7:0] p, input logic [7:0] b);
        exp_t e;
        rst = r; load = ld; data_in = d; dp_in = p; blank_in = b;
        model_step(r, ld, d, p, b);
        @(posedge clk); #1;
        rst = 1'b0; load = 1'b0;
        if (exp_q.size() == 0) begin
            chk("queue_empty", 32'd0, 32'd1);
        end else begin
            e = exp_q.pop_front();
            chk("digit", 32'(digit), 32'(e.digit));
            chk("AN", 32'(AN), 32'(e.an));
            chk("dp", 32'(dp), 32'(e.dp));
            chk("digit_idx", 32'(digit_idx), 32'(e.idx));
            chk("frame_done", 32'(frame_done), 32'(e.frame_done));
            chk("load_ack", 32'(load_ack), 32'(e.load_ack));
        end
        if (load_ack === 1'b1) ack_cnt++;
        if (frame_done === 1'b1) fd_cnt++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(0, 0, 32'h0, 8'h0, 8'h0);
    endtask

    initial begin
        // Reset for three cycles, then free-run with the reset (dark) shadow.
        for (int i = 0; i < 3; i++) cycle(1, 0, 32'hDEADBEEF, 8'hFF, 8'h00);
        chk("rst_AN", 32'(AN), 32'hFF);
        chk("rst_digit", 32'(digit), 32'h0);
        chk("rst_dp", 32'(dp), 32'h1);
        fd_cnt = 0;
        idle(64);
        chk("frames_in_64", 32'(fd_cnt), 32'd2);

        // Mid-frame load, committed at the next boundary.
        idle(5);
        ack_cnt = 0;
        cycle(0, 1, 32'h76543210, 8'h01, 8'h00);
        chk("no_early_change", 32'(AN), 32'hFF);
        idle(64);
        chk("ack_once_basic", 32'(ack_cnt), 32'd1);

        // Blank digit 3.
        ack_cnt = 0;
        cycle(0, 1, 32'h76543210, 8'h00, 8'h08);
        idle(64);
        chk("ack_once_blank", 32'(ack_cnt), 32'd1);

        // Two loads in one frame: last wins, single ack.
        while (!(m_idx == 1)) idle(1);
        ack_cnt = 0;
        cycle(0, 1, 32'h11111111, 8'h00, 8'h00);
        idle(3);
        cycle(0, 1, 32'h22222222, 8'h00, 8'h00);
        while (!(m_idx == 7 && m_presc == DIV - 1)) idle(1);
        idle(1);
        chk("last_wins_digit", 32'(digit), 32'h2);
        idle(40);
        chk("ack_once_double", 32'(ack_cnt), 32'd1);

        // Load exactly on the commit-point cycle (bypass).
        while (!(m_idx == 7 && m_presc == DIV - 1)) idle(1);
        ack_cnt = 0;
        cycle(0, 1, 32'h89ABCDEF, 8'h80, 8'h00);
        chk("bypass_digit0", 32'(digit), 32'hF);
        chk("bypass_ack", 32'(load_ack), 32'h1);
        idle(64);
        chk("ack_once_bypass", 32'(ack_cnt), 32'd1);

        // Reset during slot 5 with pending data: display goes dark, pending never shows.
        while (!(m_idx == 5)) idle(1);
        cycle(0, 1, 32'h55555555, 8'hFF, 8'h00);
        ack_cnt = 0;
        cycle(1, 1, 32'h66666666, 8'hFF, 8'h00);
        for (int i = 0; i < 70; i++) begin
            cycle(0, 0, 32'h0, 8'h0, 8'h0);
            chk("dark_AN", 32'(AN), 32'hFF);
        end
        chk("no_ack_after_rst", 32'(ack_cnt), 32'd0);

        // Random loads.
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 15) == 0)
                cycle(0, 1, $urandom, 8'($urandom), 8'($urandom));
            else
                idle(1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
